aligned_sram: RTL and testbench

ALIGNED_SRAM -- requirements
Module: aligned_sram

---
 rtl/aligned_sram.sv | 134 +++++++++++++
 tb/tb_aligned_sram.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/aligned_sram.sv
// aligned_sram: single-port word SRAM behind a byte-addressed port.
// Requests must be word aligned and inside the array; any other request is
// a fault. Faulting writes are dropped and faulting reads return zero. A
// sticky error block records the first fault and counts every faulting cycle.
//
// Read handshake: rd_en is a one-cycle request with no backpressure. Exactly
// one cycle later rd_valid is high for one cycle, with rdata/rd_err valid in
// that cycle. rd_valid is low in every other cycle, and rdata holds its last
// value while rd_valid is low. rd_valid is also forced low while rst_n is low,
// so a read issued just before reset produces no response.
module aligned_sram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  err_clr,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rd_valid,
  output logic                  rd_err,
  output logic                  err,
  output logic [ADDR_W-1:0]     err_addr,
  output logic [1:0]            err_type,
  output logic [15:0]           err_cnt
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);

  // Storage; intentionally not reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic              misaligned;
  logic              out_of_range;
  logic              req;
  logic              fault;
  logic [1:0]        cause;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [1:0]        err_type_q, err_type_d;
  logic [15:0]       err_cnt_q, err_cnt_d;

  // Address decode: any byte-offset bit set is misaligned; any bit above the
  // word index set means the address lies beyond DEPTH*BYTES.
  assign idx          = addr[OFF_W+IDX_W-1:OFF_W];
  assign misaligned   = |addr[OFF_W-1:0];
  assign out_of_range = |addr[ADDR_W-1:OFF_W+IDX_W];
  assign req          = wr_en | rd_en;
  assign fault        = req & (misaligned | out_of_range);
  assign cause        = {out_of_range, misaligned};

  // Byte-lane write of good requests; ignored during reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en && !fault) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read response next state; mem_q is sampled before this edge's write lands.
  always_comb begin
    rdata_d    = rdata_q;
    rd_valid_d = rd_en;
    rd_err_d   = rd_en & fault;
    if (rd_en) begin
      rdata_d = fault ? '0 : mem_q[idx];
    end
  end

  // Sticky error next state; a fault in the same cycle as err_clr wins.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    err_type_d = err_type_q;
    err_cnt_d  = err_cnt_q;
    if (fault) begin
      if (!err_q || err_clr) begin
        err_d      = 1'b1;
        err_addr_d = addr;
        err_type_d = cause;
      end
      if (err_clr)                   err_cnt_d = 16'd1;
      else if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end else if (err_clr) begin
      err_d      = 1'b0;
      err_addr_d = '0;
      err_type_d = 2'b00;
      err_cnt_d  = 16'd0;
    end
  end

  // Register read response and error state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_type_q <= 2'b00;
      err_cnt_q  <= 16'd0;
    end else begin
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      err_type_q <= err_type_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q & rst_n;
  assign rd_err   = rd_err_q & rst_n;
  assign err      = err_q;
  assign err_addr = err_addr_q;
  assign err_type = err_type_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_aligned_sram.sv
// tb_aligned_sram: directed and randomized checks of aligned_sram against a
// byte-array reference model with a read-data expected queue.
module tb_aligned_sram;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;
  localparam int BYTES  = DATA_W / 8;
  localparam int SPAN   = DEPTH * BYTES;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [BYTES-1:0]  be;
  logic              err_clr;
  logic [DATA_W-1:0] rdata;
  logic              rd_valid;
  logic              rd_err;
  logic              err;
  logic [ADDR_W-1:0] err_addr;
  logic [1:0]        err_type;
  logic [15:0]       err_cnt;

  aligned_sram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .be(be), .err_clr(err_clr), .rdata(rdata),
    .rd_valid(rd_valid), .rd_err(rd_err), .err(err), .err_addr(err_addr),
    .err_type(err_type), .err_cnt(err_cnt)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]        m_mem [SPAN];
  logic [DATA_W-1:0] m_rdata;
  bit                m_valid;
  bit                m_rd_err;
  bit                m_err;
  logic [ADDR_W-1:0] m_err_addr;
  logic [1:0]        m_err_type;
  int                m_err_cnt;
  logic [DATA_W-1:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [DATA_W-1:0] e;
    check("rd_valid", {63'd0, rd_valid}, {63'd0, m_valid});
    if (m_valid) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      if (rd_valid === 1'b1) begin
        check("rdata", {32'd0, rdata}, {32'd0, e});
        check("rd_err", {63'd0, rd_err}, {63'd0, m_rd_err});
      end
    end else begin
      check("rdata_hold", {32'd0, rdata}, {32'd0, m_rdata});
    end
    check("err", {63'd0, err}, {63'd0, m_err});
    check("err_addr", {32'd0, err_addr}, {32'd0, m_err_addr});
    check("err_type", {62'd0, err_type}, {62'd0, m_err_type});
    check("err_cnt", {48'd0, err_cnt}, 64'(m_err_cnt));
  endtask

  // One clock of traffic: drive, update model at the edge, check 1ns later.
  task automatic cycle(input bit wr, input bit rd, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] b, input bit clr);
    bit aligned, inr, flt;
    logic [1:0] cause;
    logic [31:0] old;
    wr_en = wr; rd_en = rd; addr = a; wdata = wd; be = b; err_clr = clr;
    @(posedge clk);
    aligned = (a % BYTES) == 0;
    inr     = a < SPAN;
    flt     = (wr || rd) && (!aligned || !inr);
    cause   = {!inr, !aligned};
    old     = '0;
    if (aligned && inr) old = {m_mem[a+3], m_mem[a+2], m_mem[a+1], m_mem[a]};
    if (rd) begin
      m_valid  = 1'b1;
      m_rd_err = flt;
      m_rdata  = flt ? '0 : old;
      exp_q.push_back(m_rdata);
    end else begin
      m_valid = 1'b0;
    end
    if (wr && !flt) begin
      for (int i = 0; i < BYTES; i++) if (b[i]) m_mem[a+i] = wd[8*i +: 8];
    end
    if (flt) begin
      if (!m_err || clr) begin
        m_err = 1'b1; m_err_addr = a; m_err_type = cause;
      end
      m_err_cnt = clr ? 1 : ((m_err_cnt >= 65535) ? 65535 : m_err_cnt + 1);
    end else if (clr) begin
      m_err = 1'b0; m_err_addr = '0; m_err_type = 2'b00; m_err_cnt = 0;
    end
    #1;
    compare_outputs();
  endtask

  // Hold reset for n edges while presenting a write that must be ignored.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    wr_en = 1'b1; rd_en = 1'b1; addr = 32'h8; wdata = $urandom(); be = 4'hF; err_clr = 1'b0;
    repeat (n) begin
      @(posedge clk);
      m_rdata = '0; m_valid = 1'b0; m_rd_err = 1'b0;
      m_err = 1'b0; m_err_addr = '0; m_err_type = 2'b00; m_err_cnt = 0;
      exp_q.delete();
      #1;
      compare_outputs();
    end
    rst_n = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k <= 6)      return 32'($urandom_range(0, DEPTH-1) * BYTES);
    else if (k == 7) return 32'($urandom_range(0, DEPTH-1) * BYTES + $urandom_range(1, BYTES-1));
    else if (k == 8) return 32'(SPAN + $urandom_range(0, 255) * BYTES);
    else             return $urandom();
  endfunction

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0; be = '0; err_clr = 1'b0;
    m_rdata = '0; m_valid = 1'b0; m_rd_err = 1'b0;
    m_err = 1'b0; m_err_addr = '0; m_err_type = 2'b00; m_err_cnt = 0;
    #2;
    do_reset(3);

    // Fill every word so the model and array start from known contents.
    for (int w = 0; w < DEPTH; w++) cycle(1, 0, 32'(w * BYTES), $urandom(), 4'hF, 0);

    // Full write then read back
    cycle(1, 0, 32'h8, 32'hDEADBEEF, 4'hF, 0);
    cycle(0, 1, 32'h8, 32'h0, 4'h0, 0);
    check("dir_full_wr", {32'd0, rdata}, 64'hDEADBEEF);
    // Partial byte-lane write
    cycle(1, 0, 32'h8, 32'h11223344, 4'b0101, 0);
    cycle(0, 1, 32'h8, 32'h0, 4'h0, 0);
    check("dir_lane_wr", {32'd0, rdata}, 64'hDE22BE44);
    // Good write with no lanes is not a fault
    cycle(1, 0, 32'h8, 32'hFFFFFFFF, 4'h0, 0);
    cycle(0, 1, 32'h8, 32'h0, 4'h0, 0);
    check("dir_be0", {32'd0, rdata}, 64'hDE22BE44);
    // Misaligned write, then out-of-range read, then verify word untouched
    cycle(1, 0, 32'h6, 32'hCAFECAFE, 4'hF, 0);
    check("dir_mis_type", {62'd0, err_type}, 64'h1);
    cycle(0, 1, 32'h400, 32'h0, 4'h0, 0);
    check("dir_oor_cnt", {48'd0, err_cnt}, 64'h2);
    check("dir_oor_addr", {32'd0, err_addr}, 64'h6);
    cycle(0, 1, 32'h4, 32'h0, 4'h0, 0);
    // Clear, then both causes at once, then clear racing a fault
    cycle(0, 0, 32'h0, 32'h0, 4'h0, 1);
    cycle(0, 1, 32'h403, 32'h0, 4'h0, 0);
    check("dir_both_type", {62'd0, err_type}, 64'h3);
    cycle(1, 0, 32'h1, 32'h0, 4'hF, 1);
    check("dir_clr_race", {48'd0, err_cnt}, 64'h1);
    // Read-before-write on a shared cycle
    cycle(1, 0, 32'h10, 32'h0BADF00D, 4'hF, 1);
    cycle(1, 1, 32'h10, 32'hA5A5A5A5, 4'hF, 0);
    check("dir_rbw_old", {32'd0, rdata}, 64'h0BADF00D);
    cycle(0, 1, 32'h10, 32'h0, 4'h0, 0);
    check("dir_rbw_new", {32'd0, rdata}, 64'hA5A5A5A5);
    cycle(0, 0, 32'h0, 32'h0, 4'h0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 1), $urandom_range(0, 1), rand_addr(), $urandom(),
            4'($urandom_range(0, 15)), $urandom_range(0, 19) == 0);
    end

    // Drive the counter across saturation
    cycle(0, 0, 32'h0, 32'h0, 4'h0, 1);
    for (int i = 0; i < 65537; i++) cycle(i % 2, (i + 1) % 2, 32'h6, 32'h0, 4'hF, 0);
    check("sat_cnt", {48'd0, err_cnt}, 64'hFFFF);

    // Read followed directly by reset yields no response
    cycle(0, 1, 32'h8, 32'h0, 4'h0, 0);
    rd_en = 1'b0; rst_n = 1'b0;
    #1;
    check("rst_rdv", {63'd0, rd_valid}, 64'h0);
    do_reset(1);
    // Memory survives reset and ignores the write presented during reset
    cycle(0, 1, 32'h8, 32'h0, 4'h0, 0);
    cycle(0, 0, 32'h0, 32'h0, 4'h0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
